fp_mul_pipe: RTL and testbench

- Parametrised, 3-stage pipelined IEEE-754-style floating-point multiplier with a valid/ready handshake.
- Successor to the team's combinational FP32 multiplier, used as the multiply stage of systolic-array processing elements.
- Adds:
  - configurable exponent and mantissa widths;
  - special-value handling for zero, inf and NaN;
  - overflow and underflow saturation;
  - exception flags;
  - backpressure.

---
 rtl/fp_mul_pipe.sv | 175 +++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// 3-stage pipelined floating-point multiplier (flush-to-zero, saturating) with a valid/ready stall.
// Define FP_MUL_RNE_EN for round-to-nearest-even; otherwise results are truncated toward zero.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_data,
    output logic [3:0]           out_flags
);
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE     = EW'(1);
    localparam logic signed [EW-1:0] ZERO    = '0;

    // Handshake: a transfer happens on a rising edge where valid && ready. The whole
    // pipe moves as one; it stalls only when a result sits at the output unaccepted.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    logic                 sa, sb;
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     fa, fb;
    logic                 a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic signed [EW-1:0] exp_sum;
    logic [PW-1:0]        prod;

    assign {sa, ea, fa} = in_a;
    assign {sb, eb, fb} = in_b;
    assign a_zero  = (ea == '0);
    assign b_zero  = (eb == '0);
    assign a_inf   = (&ea) && (fa == '0);
    assign b_inf   = (&eb) && (fb == '0);
    assign a_nan   = (&ea) && (fa != '0);
    assign b_nan   = (&eb) && (fb != '0);
    assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    assign prod    = PW'({1'b1, fa}) * PW'({1'b1, fb});

    logic                 s1_valid, s1_sign, s1_nan, s1_inf, s1_zero;
    logic signed [EW-1:0] s1_exp;
    logic [PW-1:0]        s1_prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_nan   <= 1'b0;
            s1_inf   <= 1'b0;
            s1_zero  <= 1'b0;
            s1_exp   <= '0;
            s1_prod  <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_sign  <= sa ^ sb;
            s1_nan   <= a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
            s1_inf   <= a_inf || b_inf;
            s1_zero  <= a_zero || b_zero;
            s1_exp   <= exp_sum;
            s1_prod  <= prod;
        end
    end

    // Significand product lies in [1,4): normalise by at most one position.
    logic                 norm, n_guard, n_sticky;
    logic signed [EW-1:0] n_exp;
    logic [MAN_W-1:0]     n_frac;

    assign norm = s1_prod[PW-1];

    always_comb begin
        if (norm) begin
            n_exp    = s1_exp + ONE;
            n_frac   = s1_prod[PW-2 -: MAN_W];
            n_guard  = s1_prod[MAN_W];
            n_sticky = |s1_prod[MAN_W-1:0];
        end else begin
            n_exp    = s1_exp;
            n_frac   = s1_prod[PW-3 -: MAN_W];
            n_guard  = s1_prod[MAN_W-1];
            n_sticky = |s1_prod[MAN_W-2:0];
        end
    end

    logic                 s2_valid, s2_sign, s2_nan, s2_inf, s2_zero, s2_guard, s2_sticky;
    logic signed [EW-1:0] s2_exp;
    logic [MAN_W-1:0]     s2_frac;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_nan    <= 1'b0;
            s2_inf    <= 1'b0;
            s2_zero   <= 1'b0;
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
            s2_exp    <= '0;
            s2_frac   <= '0;
        end else if (advance) begin
            s2_valid  <= s1_valid;
            s2_sign   <= s1_sign;
            s2_nan    <= s1_nan;
            s2_inf    <= s1_inf;
            s2_zero   <= s1_zero;
            s2_guard  <= n_guard;
            s2_sticky <= n_sticky;
            s2_exp    <= n_exp;
            s2_frac   <= n_frac;
        end
    end

    logic signed [EW-1:0] r_exp;
    logic [MAN_W-1:0]     r_frac;
    logic                 lost;

    assign lost = s2_guard || s2_sticky;

`ifdef FP_MUL_RNE_EN
    logic round_up, r_carry;
    assign round_up          = s2_guard && (s2_sticky || s2_frac[0]);
    assign {r_carry, r_frac} = {1'b0, s2_frac} + (MAN_W + 1)'(round_up);
    // A carry leaves the fraction at zero: significand 10.0 becomes 1.0 with exponent + 1.
    assign r_exp             = r_carry ? (s2_exp + ONE) : s2_exp;
`else
    assign r_frac = s2_frac;
    assign r_exp  = s2_exp;
`endif

    logic [EXP_W+MAN_W:0] res;
    logic [3:0]           res_flags;

    always_comb begin
        res       = {s2_sign, r_exp[EXP_W-1:0], r_frac};
        res_flags = {3'b000, lost};
        if (s2_nan) begin
            res       = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            res_flags = 4'b1000;
        end else if (s2_inf) begin
            res       = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            res_flags = 4'b0000;
        end else if (s2_zero) begin
            res       = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
            res_flags = 4'b0000;
        end else if (r_exp >= EXP_MAX) begin
            res       = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            res_flags = 4'b0101;
        end else if (r_exp <= ZERO) begin
            res       = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
            res_flags = 4'b0011;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_flags <= '0;
        end else if (advance) begin
            out_valid <= s2_valid;
            out_data  <= res;
            out_flags <= res_flags;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed-vector bench for fp_mul_pipe at FP32 widths.
module tb_fp_mul_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_flags;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    // Driver: one operand pair with out_ready high; returns result and latency (-1 on timeout).
    task automatic mul_one(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] d, output logic [3:0] f, output int lat);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        d = out_data;
        f = out_flags;
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_vec++;
        if (out_data !== 32'h0) begin
            n_err++; $display("FAIL reset_out_data: got %h expected 00000000", out_data);
        end
        n_vec++;
        if (out_flags !== 4'h0) begin
            n_err++; $display("FAIL reset_out_flags: got %b expected 0000", out_flags);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_basic;
        logic [31:0] d;
        logic [3:0]  f;
        int          lat;
        mul_one(32'h3FC00000, 32'h40000000, d, f, lat);
        n_vec++;
        if (lat != 3) begin
            n_err++; $display("FAIL basic_latency: got %0d expected 3", lat);
        end
        n_vec++;
        if (d !== 32'h40400000) begin
            n_err++; $display("FAIL basic_data: got %h expected 40400000", d);
        end
        n_vec++;
        if (f !== 4'b0000) begin
            n_err++; $display("FAIL basic_flags: got %b expected 0000", f);
        end
    endtask

    task automatic test_rounding;
        logic [31:0] d;
        logic [3:0]  f;
        int          lat;
        logic [31:0] want;
`ifdef FP_MUL_RNE_EN
        want = 32'h40100002;
`else
        want = 32'h40100001;
`endif
        mul_one(32'h3FC00001, 32'h3FC00001, d, f, lat);
        n_vec++;
        if (d !== want) begin
            n_err++; $display("FAIL round_data: got %h expected %h", d, want);
        end
        n_vec++;
        if (f !== 4'b0001) begin
            n_err++; $display("FAIL round_flags: got %b expected 0001", f);
        end
    endtask

    task automatic test_specials;
        logic [31:0] va[4], vb[4], vd[4];
        logic [3:0]  vf[4];
        logic [31:0] d;
        logic [3:0]  f;
        int          lat;
        va[0] = 32'h7F800000; vb[0] = 32'h00000000; vd[0] = 32'h7FC00000; vf[0] = 4'b1000;
        va[1] = 32'hFF800000; vb[1] = 32'h40000000; vd[1] = 32'hFF800000; vf[1] = 4'b0000;
        va[2] = 32'h80000000; vb[2] = 32'h3F800000; vd[2] = 32'h80000000; vf[2] = 4'b0000;
        va[3] = 32'h00000001; vb[3] = 32'h3F800000; vd[3] = 32'h00000000; vf[3] = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            mul_one(va[i], vb[i], d, f, lat);
            n_vec++;
            if (d !== vd[i]) begin
                n_err++; $display("FAIL special_%0d_data: got %h expected %h", i, d, vd[i]);
            end
            n_vec++;
            if (f !== vf[i]) begin
                n_err++; $display("FAIL special_%0d_flags: got %b expected %b", i, f, vf[i]);
            end
        end
    endtask

    task automatic test_range;
        logic [31:0] d;
        logic [3:0]  f;
        int          lat;
        mul_one(32'h7F000000, 32'h40000000, d, f, lat);
        n_vec++;
        if (d !== 32'h7F800000) begin
            n_err++; $display("FAIL overflow_data: got %h expected 7f800000", d);
        end
        n_vec++;
        if (f !== 4'b0101) begin
            n_err++; $display("FAIL overflow_flags: got %b expected 0101", f);
        end
        mul_one(32'h00800000, 32'h3F000000, d, f, lat);
        n_vec++;
        if (d !== 32'h00000000) begin
            n_err++; $display("FAIL underflow_data: got %h expected 00000000", d);
        end
        n_vec++;
        if (f !== 4'b0011) begin
            n_err++; $display("FAIL underflow_flags: got %b expected 0011", f);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] va[5], vb[5], ve[5];
        logic [31:0] held_d, e;
        logic [3:0]  held_f;
        bit          holding, saw_block, fire_in, fire_out;
        int          sent, got, cyc, sent_at_block;
        va[0] = 32'h3FC00000; vb[0] = 32'h40000000; ve[0] = 32'h40400000;
        va[1] = 32'h40000000; vb[1] = 32'h40000000; ve[1] = 32'h40800000;
        va[2] = 32'h3F800000; vb[2] = 32'h3F800000; ve[2] = 32'h3F800000;
        va[3] = 32'h40400000; vb[3] = 32'h3F000000; ve[3] = 32'h3FC00000;
        va[4] = 32'hC0000000; vb[4] = 32'h3FC00000; ve[4] = 32'hC0400000;
        holding = 0; saw_block = 0; sent = 0; got = 0; cyc = 0; sent_at_block = -1;
        held_d = '0; held_f = '0;
        exp_q.delete();
        @(posedge clk); #1;
        while (got < 5 && cyc < 60) begin
            out_ready = (cyc < 2 || cyc >= 12);
            in_valid  = (sent < 5);
            if (sent < 5) begin
                in_a = va[sent];
                in_b = vb[sent];
            end
            #1;
            if (out_valid && !out_ready) begin
                if (!holding) begin
                    held_d  = out_data;
                    held_f  = out_flags;
                    holding = 1;
                end else begin
                    n_vec++;
                    if (out_data !== held_d || out_flags !== held_f) begin
                        n_err++;
                        $display("FAIL stall_stable: got %h/%b expected %h/%b", out_data, out_flags, held_d, held_f);
                    end
                end
            end else begin
                holding = 0;
            end
            if (in_valid && !in_ready && !saw_block) begin
                saw_block     = 1;
                sent_at_block = sent;
            end
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL bp_order: got %h expected no result", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_err++; $display("FAIL bp_order: got %h expected %h", out_data, e);
                    end
                end
                got++;
            end
            if (fire_in) begin
                exp_q.push_back(ve[sent]);
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_vec++;
        if (!saw_block || sent_at_block != 3) begin
            n_err++; $display("FAIL bp_in_ready_drop: got blocked=%0b at pair %0d expected blocked=1 at pair 3", saw_block, sent_at_block);
        end
        n_vec++;
        if (got != 5) begin
            n_err++; $display("FAIL bp_count: got %0d results expected 5", got);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL bp_leftover: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midstream;
        logic [31:0] d;
        logic [3:0]  f;
        int          lat, stale;
        out_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = 32'h40000000;
            in_b     = 32'h3F800000;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL midrst_inflight: got %b expected 1", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL midrst_async_valid: got %b expected 0", out_valid);
        end
        n_vec++;
        if (out_data !== 32'h0) begin
            n_err++; $display("FAIL midrst_async_data: got %h expected 00000000", out_data);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        stale = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        n_vec++;
        if (stale != 0) begin
            n_err++; $display("FAIL midrst_stale: got %0d valid cycles expected 0", stale);
        end
        mul_one(32'h3F800000, 32'h3F800000, d, f, lat);
        n_vec++;
        if (d !== 32'h3F800000 || lat != 3) begin
            n_err++; $display("FAIL midrst_recover: got %h lat %0d expected 3f800000 lat 3", d, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_specials();
        test_range();
        test_backpressure();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
